// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler between the 2-way data cache and main memory.
// On a miss it writes back a dirty victim line word by word, then fetches the
// missing line word by word and streams it into the cache array. o_busy stalls
// the pipeline until the line is installed; o_done pulses for one cycle at the end.
// Optional build macro CRITICAL_WORD_FIRST_EN: the fill starts at the missed word
// and wraps around the line. Without it the fill runs in index order 0..N-1.
// The writeback always runs 0..N-1.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_miss_valid,
  output logic                             o_miss_ready,
  input  logic [ADDR_WIDTH-1:0]            i_miss_addr,
  input  logic                             i_victim_dirty,
  input  logic [ADDR_WIDTH-1:0]            i_victim_addr,
  output logic [$clog2(BLOCK_WORDS)-1:0]   o_victim_idx,
  input  logic [DATA_WIDTH-1:0]            i_victim_data,
  output logic                             o_mem_req,
  output logic                             o_mem_we,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic [DATA_WIDTH-1:0]            o_mem_wdata,
  input  logic                             i_mem_ack,
  input  logic [DATA_WIDTH-1:0]            i_mem_rdata,
  output logic                             o_fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0]   o_fill_idx,
  output logic [DATA_WIDTH-1:0]            o_fill_data,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int OFF   = $clog2(BLOCK_WORDS);
  localparam int TAG_W = ADDR_WIDTH - OFF - 2;
  localparam logic [OFF:0] LAST_K = (OFF+1)'(BLOCK_WORDS - 1);
  localparam logic [OFF:0] K_ONE  = (OFF+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // Beat counter; one spare bit so the last-beat compare covers the full range.
  logic [OFF:0]      r_k;
  logic [OFF:0]      w_kNext;

  // Only the line-number part of each base address is kept; the word and byte
  // fields are rebuilt from the beat index, so addresses never carry out of a line.
  logic [TAG_W-1:0]  r_lineTag;
  logic [TAG_W-1:0]  r_victimTag;
  logic [OFF-1:0]    r_offset;

  logic              w_accept;
  logic              w_lastBeat;
  logic [OFF-1:0]    w_beatIdx;
  logic [OFF-1:0]    w_fillIdx;
  logic              w_unused;

  assign w_accept   = i_miss_valid && (r_state == IDLE);
  assign w_lastBeat = (r_k == LAST_K);
  assign w_beatIdx  = r_k[OFF-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
  // Modulo add in OFF bits gives the wrap-around order starting at the missed word.
  assign w_fillIdx = r_offset + w_beatIdx;
  assign w_unused  = ^{1'b0, i_miss_addr[1:0], i_victim_addr[OFF+1:0]};
`else
  assign w_fillIdx = w_beatIdx;
  assign w_unused  = ^{1'b0, i_miss_addr[1:0], i_victim_addr[OFF+1:0], r_offset};
`endif

  // State register and beat counter; an async reset abandons any transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_stateNext;
      r_k     <= w_kNext;
    end
  end

  // Capture the line base, victim base and missed word offset when a miss is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lineTag   <= '0;
      r_victimTag <= '0;
      r_offset    <= '0;
    end else if (w_accept) begin
      r_lineTag   <= i_miss_addr[ADDR_WIDTH-1:OFF+2];
      r_victimTag <= i_victim_addr[ADDR_WIDTH-1:OFF+2];
      r_offset    <= i_miss_addr[OFF+1:2];
    end
  end

  // Next-state, counter and output decode; the counter clears on every state change.
  always_comb begin
    w_stateNext  = r_state;
    w_kNext      = r_k;
    o_miss_ready = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_victim_idx = '0;
    o_fill_we    = 1'b0;
    o_fill_idx   = '0;
    o_fill_data  = '0;

    case (r_state)
      IDLE: begin
        o_miss_ready = 1'b1;
        o_busy       = 1'b0;
        w_kNext      = '0;
        if (w_accept) begin
          w_stateNext = i_victim_dirty ? WB : FILL;
        end
      end

      WB: begin
        o_mem_req    = 1'b1;
        o_mem_we     = 1'b1;
        o_mem_addr   = {r_victimTag, w_beatIdx, 2'b00};
        o_mem_wdata  = i_victim_data;
        o_victim_idx = w_beatIdx;
        if (i_mem_ack) begin
          if (w_lastBeat) begin
            w_stateNext = FILL;
            w_kNext     = '0;
          end else begin
            w_kNext = r_k + K_ONE;
          end
        end
      end

      FILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_lineTag, w_fillIdx, 2'b00};
        o_fill_idx = w_fillIdx;
        if (i_mem_ack) begin
          o_fill_we   = 1'b1;
          o_fill_data = i_mem_rdata;
          if (w_lastBeat) begin
            w_stateNext = DONE;
            w_kNext     = '0;
          end else begin
            w_kNext = r_k + K_ONE;
          end
        end
      end

      DONE: begin
        o_done      = 1'b1;
        w_kNext     = '0;
        w_stateNext = IDLE;
      end

      default: begin
        w_stateNext = IDLE;
        w_kNext     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed bench for cache_refill_ctrl with a transaction
// model that predicts every memory beat from the miss and victim addresses.
module tb_cache_refill_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int OFF = 2;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic missValid = 1'b0;
  logic missReady;
  logic [AW-1:0] missAddr = '0;
  logic victimDirty = 1'b0;
  logic [AW-1:0] victimAddr = '0;
  logic [OFF-1:0] victimIdx;
  logic [DW-1:0] victimData;
  logic memReq, memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic memAck = 1'b0;
  logic [DW-1:0] memRdata = '0;
  logic fillWe;
  logic [OFF-1:0] fillIdx;
  logic [DW-1:0] fillData;
  logic busy, done;

  int nChecks = 0;
  int nPass = 0;
  int cycleCnt = 0;
  int memLat = 0;
  int waitCnt = 0;
  bit strayAck = 1'b0;
  int acceptCount = 0;

  logic [31:0] obsAddr[$];
  logic        obsWe[$];
  logic [31:0] obsWdata[$];
  logic [1:0]  obsIdx[$];

  cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_miss_valid(missValid), .o_miss_ready(missReady), .i_miss_addr(missAddr),
    .i_victim_dirty(victimDirty), .i_victim_addr(victimAddr),
    .o_victim_idx(victimIdx), .i_victim_data(victimData),
    .o_mem_req(memReq), .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_ack(memAck), .i_mem_rdata(memRdata),
    .o_fill_we(fillWe), .o_fill_idx(fillIdx), .o_fill_data(fillData),
    .o_busy(busy), .o_done(done)
  );

  // Victim line contents as seen by the cache: word j holds C0DE_000j.
  assign victimData = 32'hC0DE_0000 | 32'(victimIdx);

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Memory responder: acks after memLat wait cycles, read data derived from the address.
  always @(posedge clk) begin
    #1;
    if (memReq && rstN) begin
      if (waitCnt >= memLat) begin
        memAck = 1'b1;
        waitCnt = 0;
      end else begin
        memAck = 1'b0;
        waitCnt++;
      end
    end else begin
      memAck = strayAck;
      waitCnt = 0;
    end
    memRdata = memAddr ^ 32'hA5A5_0000;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  idx;
  } beat_t;

  beat_t expQ[$];
  beat_t mb;
  int phase = 0;

  // Transaction model: on accept it lists every beat the miss must produce, then
  // checks the DUT against the head of that list on every cycle.
  always @(negedge clk) begin
    if (!rstN) begin
      checkOutput("reset_ctrl", {busy, missReady, memReq, fillWe, done}, 5'b01000);
      expQ.delete();
      phase = 0;
    end else begin
      case (phase)
        0: begin
          checkOutput("idle_ctrl", {busy, missReady, done, memReq, fillWe}, 5'b01000);
          if (missValid) begin
            acceptCount++;
            if (victimDirty) begin
              for (int j = 0; j < BW; j++) begin
                mb.we = 1'b1;
                mb.addr = (victimAddr & ~32'(BW*4-1)) + 32'(4*j);
                mb.data = 32'hC0DE_0000 | 32'(j);
                mb.idx = 2'(j);
                expQ.push_back(mb);
              end
            end
            for (int j = 0; j < BW; j++) begin
              int widx;
`ifdef CRITICAL_WORD_FIRST_EN
              widx = (int'((missAddr >> 2) % BW) + j) % BW;
`else
              widx = j;
`endif
              mb.we = 1'b0;
              mb.addr = (missAddr & ~32'(BW*4-1)) + 32'(4*widx);
              mb.data = mb.addr ^ 32'hA5A5_0000;
              mb.idx = 2'(widx);
              expQ.push_back(mb);
            end
            phase = 1;
          end
        end
        1: begin
          if (expQ.size() == 0) begin
            checkOutput("model_underflow", 1, 0);
            phase = 0;
          end else begin
            checkOutput("xfer_ctrl", {busy, missReady, done, memReq}, 4'b1001);
            checkOutput("xfer_req", {memWe, memAddr}, {expQ[0].we, expQ[0].addr});
            if (expQ[0].we) checkOutput("wb_data", memWdata, expQ[0].data);
            if (memAck) begin
              if (expQ[0].we) checkOutput("wb_nofill", fillWe, 0);
              else checkOutput("fill_beat", {fillWe, fillIdx, fillData},
                               {1'b1, expQ[0].idx, expQ[0].data});
              void'(expQ.pop_front());
              if (expQ.size() == 0) phase = 2;
            end else begin
              checkOutput("wait_nofill", fillWe, 0);
            end
          end
        end
        default: begin
          checkOutput("done_ctrl", {busy, missReady, done, memReq, fillWe}, 5'b10100);
          phase = 0;
        end
      endcase
    end
  end

  // Waits for o_done, counting busy cycles and recording every acked beat.
  task automatic waitDone(input int acc, output int latency, output int busyCycles);
    bit seen = 1'b0;
    latency = -1;
    busyCycles = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (memReq && memAck) begin
        obsAddr.push_back(memAddr);
        obsWe.push_back(memWe);
        obsWdata.push_back(memWdata);
      end
      if (fillWe) obsIdx.push_back(fillIdx);
      if (done) begin
        latency = cycleCnt - acc;
        seen = 1'b1;
      end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  // Presents a miss, waits for accept; optionally keeps miss_valid asserted.
  task automatic startMiss(input logic [31:0] mAddr, input bit dirty, input logic [31:0] vAddr,
                           input bit hold, output int acc);
    bit got = 1'b0;
    acc = -1;
    @(posedge clk); #1;
    missAddr = mAddr;
    victimDirty = dirty;
    victimAddr = vAddr;
    missValid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (missReady) begin
        got = 1'b1;
        acc = cycleCnt;
      end
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    if (!hold) begin
      @(posedge clk); #1;
      missValid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] mAddr, input bit dirty, input logic [31:0] vAddr,
                               input int lat, output int latency, output int busyCycles);
    int acc;
    obsAddr.delete(); obsWe.delete(); obsWdata.delete(); obsIdx.delete();
    memLat = lat;
    startMiss(mAddr, dirty, vAddr, 1'b0, acc);
    waitDone(acc, latency, busyCycles);
  endtask

  task automatic checkReadOrder(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3, input int first);
    logic [31:0] ea [4];
    ea = '{a0, a1, a2, a3};
    checkOutput({tag, "_beats"}, obsAddr.size(), first + 4);
    for (int i = 0; i < 4 && first + i < obsAddr.size(); i++) begin
      checkOutput({tag, "_rd_addr"}, obsAddr[first+i], ea[i]);
      checkOutput({tag, "_rd_we"}, obsWe[first+i], 0);
    end
  endtask

  task automatic checkFillIdx(input string tag, input logic [1:0] i0, input logic [1:0] i1,
                              input logic [1:0] i2, input logic [1:0] i3);
    logic [1:0] ei [4];
    ei = '{i0, i1, i2, i3};
    checkOutput({tag, "_fill_pulses"}, obsIdx.size(), 4);
    for (int i = 0; i < 4 && i < obsIdx.size(); i++)
      checkOutput({tag, "_fill_idx"}, obsIdx[i], ei[i]);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, bc, acc, done1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("por_state", {busy, missReady, memReq, fillWe, done}, 5'b01000);
    @(posedge clk); #1;
    rstN = 1'b1;

    // Reset in the middle of the fill abandons the transfer.
    memLat = 0;
    startMiss(32'h0000_1034, 1'b0, 32'h0, 1'b0, acc);
    for (int i = 0; i < 20 && !fillWe; i++) @(negedge clk);
    checkOutput("t1_fill_started", fillWe, 1);
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    checkOutput("t1_async_reset", {busy, memReq, fillWe, missReady}, 4'b0001);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t1_post_reset", {busy, memReq, fillWe, missReady}, 4'b0001);

    // Clean miss with single-cycle acks.
    applyStimulus(32'h0000_1034, 1'b0, 32'h0, 0, lat, bc);
    checkOutput("t2_latency", lat, 5);
    checkOutput("t2_busy_cycles", bc, 5);
    checkReadOrder("t2", 32'h1030, 32'h1034, 32'h1038, 32'h103C, 0);
    checkFillIdx("t2", 2'd0, 2'd1, 2'd2, 2'd3);

    // Dirty miss: writeback of the victim line, then the fill.
    applyStimulus(32'h0000_1034, 1'b1, 32'h0000_2030, 0, lat, bc);
    checkOutput("t3_latency", lat, 9);
    for (int i = 0; i < 4 && i < obsAddr.size(); i++) begin
      checkOutput("t3_wb_addr", obsAddr[i], 32'h2030 + 32'(4*i));
      checkOutput("t3_wb_we", obsWe[i], 1);
      checkOutput("t3_wb_data", obsWdata[i], 32'hC0DE_0000 + 32'(i));
    end
    checkReadOrder("t3", 32'h1030, 32'h1034, 32'h1038, 32'h103C, 4);

    // Memory with three wait cycles per beat.
    applyStimulus(32'h0000_1034, 1'b0, 32'h0, 3, lat, bc);
    checkOutput("t4_latency", lat, 17);
    checkFillIdx("t4", 2'd0, 2'd1, 2'd2, 2'd3);

    // Miss on word 2: fill order depends on the critical-word-first build.
    applyStimulus(32'h0000_1038, 1'b0, 32'h0, 0, lat, bc);
    checkOutput("t5_latency", lat, 5);
`ifdef CRITICAL_WORD_FIRST_EN
    checkReadOrder("t5", 32'h1038, 32'h103C, 32'h1030, 32'h1034, 0);
    checkFillIdx("t5", 2'd2, 2'd3, 2'd0, 2'd1);
`else
    checkReadOrder("t5", 32'h1030, 32'h1034, 32'h1038, 32'h103C, 0);
    checkFillIdx("t5", 2'd0, 2'd1, 2'd2, 2'd3);
`endif

    // Stray ack while idle, then miss_valid held through DONE.
    memLat = 0;
    @(posedge clk); #1;
    strayAck = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_stray_nofill", {fillWe, memReq, busy}, 3'b000);
    @(posedge clk); #1;
    strayAck = 1'b0;
    done1 = acceptCount;
    obsAddr.delete(); obsWe.delete(); obsWdata.delete(); obsIdx.delete();
    startMiss(32'h0000_1034, 1'b0, 32'h0, 1'b1, acc);
    waitDone(acc, lat, bc);
    checkOutput("t6_first_latency", lat, 5);
    @(negedge clk);
    checkOutput("t6_reaccept_ready", missReady, 1);
    acc = cycleCnt;
    @(posedge clk); #1;
    missValid = 1'b0;
    waitDone(acc, lat, bc);
    checkOutput("t6_second_latency", lat, 5);
    checkOutput("t6_accepts", acceptCount - done1, 2);
    checkOutput("t6_fill_pulses", obsIdx.size(), 8);
    repeat (3) @(negedge clk);
    checkOutput("t6_final_idle", {busy, missReady}, 2'b01);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
